// File: rtl/user_input_pkg.sv
// Shared types and constants for the ATM field collector.
//   field_e  : which field is being typed (account, password, amount, currency)
//   state_e  : collector FSM states
//   ST_*     : status_code values reported to the main ATM state machine
//   ASCII_*  : control characters recognised by the classifier
package user_input_pkg;

  typedef enum logic [1:0] {
    FIELD_ACCT = 2'd0,
    FIELD_PSWD = 2'd1,
    FIELD_AMT  = 2'd2,
    FIELD_CUR  = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [3:0] ST_OK      = 4'd0;
  localparam logic [3:0] ST_BUSY    = 4'd1;
  localparam logic [3:0] ST_BADCHAR = 4'd2;
  localparam logic [3:0] ST_TOOMANY = 4'd3;
  localparam logic [3:0] ST_TOOFEW  = 4'd4;
  localparam logic [3:0] ST_RANGE   = 4'd5;
  localparam logic [3:0] ST_CANCEL  = 4'd6;

  localparam logic [7:0] ASCII_ENTER = 8'h0D;
  localparam logic [7:0] ASCII_BKSP  = 8'h08;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // 10^n, used to size-check the binary result at elaboration.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/ascii_classify.sv
// Combinational decode of one ASCII character.
//   ascii_code_i : typed character
//   is_digit_o   : '0'..'9'; digit_o carries its BCD value
//   is_enter_o / is_bksp_o / is_esc_o : control keys
module ascii_classify
  import user_input_pkg::*;
(
  input  logic [7:0] ascii_code_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o,
  output logic       is_enter_o,
  output logic       is_bksp_o,
  output logic       is_esc_o
);

  assign is_digit_o = (ascii_code_i >= ASCII_ZERO) && (ascii_code_i <= ASCII_ZERO + 8'd9);
  // Low nibble of '0'..'9' is already the BCD digit.
  assign digit_o    = ascii_code_i[3:0];
  assign is_enter_o = (ascii_code_i == ASCII_ENTER);
  assign is_bksp_o  = (ascii_code_i == ASCII_BKSP);
  assign is_esc_o   = (ascii_code_i == ASCII_ESC);

endmodule

// File: rtl/user_input_field.sv
// Keypad field collector: buffers typed BCD digits with editing, validates
// them against the selected field rule, converts to binary MSD first and
// signals completion with a one-cycle done pulse.
//   clk, rst            : clock, async active-high reset
//   ascii_code/_valid   : character strobe from the keyboard decoder
//   start, field_sel    : begin a new field of the given type
//   busy, done          : collecting/converting, one-cycle completion pulse
//   field_id, value     : latched field type, binary result
//   digit_count         : digits currently buffered
//   status_code         : ST_* code from user_input_pkg
module user_input_field
  import user_input_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int VAL_W          = 16,
  parameter int NUM_CURRENCIES = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        ascii_code,
  input  logic                              ascii_valid,
  input  logic                              start,
  input  logic [1:0]                        field_sel,
  output logic                              busy,
  output logic                              done,
  output logic [1:0]                        field_id,
  output logic [VAL_W-1:0]                  value,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
  output logic [3:0]                        status_code
);

  localparam int CW = $clog2(MAX_DIGITS+1);
  localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  if (VAL_W < 63) begin : g_chk
    if (pow10(MAX_DIGITS) - 1 > (longint'(1) << VAL_W) - 1) begin : g_bad_width
      $error("VAL_W too narrow for MAX_DIGITS decimal digits");
    end
  end

  state_e                     state_q, state_d;
  field_e                     fid_q, fid_d;
  logic [MAX_DIGITS-1:0][3:0] bcd_q, bcd_d;   // [0] is the least significant digit
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              idx_q, idx_d;   // digit being converted, counts down
  logic [VAL_W-1:0]           val_q, val_d;
  logic [3:0]                 stat_q, stat_d;
  logic                       done_q, done_d;

  logic       c_digit_v, c_enter, c_bksp, c_esc;
  logic [3:0] c_digit;
  logic [CW-1:0] lim;
  logic       count_ok, range_ok;

  ascii_classify u_cls (
    .ascii_code_i (ascii_code),
    .is_digit_o   (c_digit_v),
    .digit_o      (c_digit),
    .is_enter_o   (c_enter),
    .is_bksp_o    (c_bksp),
    .is_esc_o     (c_esc)
  );

  assign lim = (fid_q == FIELD_CUR) ? CW'(1) : CW'(MAX_DIGITS);

  always_comb begin
    count_ok = 1'b0;
    case (fid_q)
      FIELD_ACCT, FIELD_PSWD: count_ok = (cnt_q == CW'(MAX_DIGITS));
      FIELD_AMT:              count_ok = (cnt_q != '0);
      default:                count_ok = (cnt_q == CW'(1));
    endcase
  end

  assign range_ok = (fid_q != FIELD_CUR) || (int'(bcd_q[0]) < NUM_CURRENCIES);

  always_comb begin
    state_d = state_q;
    fid_d   = fid_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    stat_d  = stat_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (start) begin
          // start beats a coincident character strobe
          bcd_d   = '0;
          cnt_d   = '0;
          val_d   = '0;
          fid_d   = field_e'(field_sel);
          stat_d  = ST_BUSY;
          state_d = S_COLLECT;
        end else if (state_q == S_COLLECT && ascii_valid) begin
          if (c_digit_v) begin
            if (cnt_q < lim) begin
              for (int i = MAX_DIGITS-1; i > 0; i--) bcd_d[i] = bcd_q[i-1];
              bcd_d[0] = c_digit;
              cnt_d    = cnt_q + CW'(1);
              stat_d   = ST_BUSY;
            end else begin
              stat_d = ST_TOOMANY;
            end
          end else if (c_bksp) begin
            if (cnt_q != '0) begin
              for (int i = 0; i < MAX_DIGITS-1; i++) bcd_d[i] = bcd_q[i+1];
              bcd_d[MAX_DIGITS-1] = '0;
              cnt_d = cnt_q - CW'(1);
            end
            stat_d = ST_BUSY;
          end else if (c_esc) begin
            val_d   = '0;
            stat_d  = ST_CANCEL;
            state_d = S_DONE;
          end else if (c_enter) begin
            if (!count_ok) begin
              stat_d = ST_TOOFEW;
            end else if (!range_ok) begin
              stat_d = ST_RANGE;
            end else begin
              idx_d   = IW'(cnt_q - CW'(1));
              stat_d  = ST_BUSY;
              state_d = S_CONVERT;
            end
          end else begin
            stat_d = ST_BADCHAR;
          end
        end
      end
      S_CONVERT: begin
        val_d = val_q * VAL_W'(10) + VAL_W'(bcd_q[idx_q]);
        if (idx_q == '0) state_d = S_DONE;
        else             idx_d   = idx_q - IW'(1);
      end
      S_DONE: begin
        // done is registered, so it appears in the cycle after DONE
        done_d  = 1'b1;
        if (stat_q != ST_CANCEL) stat_d = ST_OK;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fid_q   <= FIELD_ACCT;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      stat_q  <= ST_OK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fid_q   <= fid_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      stat_q  <= stat_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == S_COLLECT) || (state_q == S_CONVERT);
  assign done        = done_q;
  assign field_id    = fid_q;
  assign value       = val_q;
  assign digit_count = cnt_q;
  assign status_code = stat_q;

endmodule

// File: tb/tb_user_input_field.sv
module tb_user_input_field;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ascii_code;
  logic        ascii_valid;
  logic        start;
  logic [1:0]  field_sel;
  logic        busy, done;
  logic [1:0]  field_id;
  logic [15:0] value;
  logic [2:0]  digit_count;
  logic [3:0]  status_code;

  int checks = 0;
  int errors = 0;

  user_input_field #(.MAX_DIGITS(4), .VAL_W(16), .NUM_CURRENCIES(3)) dut (
    .clk(clk), .rst(rst), .ascii_code(ascii_code), .ascii_valid(ascii_valid),
    .start(start), .field_sel(field_sel), .busy(busy), .done(done),
    .field_id(field_id), .value(value), .digit_count(digit_count),
    .status_code(status_code)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] c);
    ascii_code = c; ascii_valid = 1'b1;
    tick;
    ascii_valid = 1'b0;
  endtask

  task automatic start_field(input logic [1:0] f);
    field_sel = f; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Call right after the Enter tick; n counts cycles including the Enter cycle.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ascii_code = 8'h00; ascii_valid = 1'b0; start = 1'b0; field_sel = 2'd0;
    tick; tick;
    checks++; if ({busy, done, field_id, value, digit_count, status_code} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {busy, done, field_id, value, digit_count, status_code}); end
    rst = 1'b0;
    tick;
    key("5");
    checks++; if (digit_count !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: count %0d busy %0b required 0 0", digit_count, busy); end
  endtask

  task automatic test_account;
    int n;
    start_field(2'd0);
    checks++; if (status_code !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL acct_start: status %0d busy %0b required 1 1", status_code, busy); end
    key("1"); key("2"); key("3"); key("4");
    checks++; if (digit_count !== 3'd4) begin
      errors++; $display("FAIL acct_count: got %0d required 4", digit_count); end
    key(8'h0D);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL acct_convert_busy: busy %0b done %0b required 1 0", busy, done); end
    wait_done(n);
    checks++; if (done !== 1'b1 || n != 6) begin
      errors++; $display("FAIL acct_latency: done %0b after %0d cycles required 1 after 6", done, n); end
    checks++; if (value !== 16'd1234 || status_code !== 4'd0 || field_id !== 2'd0) begin
      errors++; $display("FAIL acct_result: value %0d status %0d id %0d required 1234 0 0", value, status_code, field_id); end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL acct_busy_done: got %0b required 0", busy); end
    tick;
    checks++; if (done !== 1'b0 || value !== 16'd1234) begin
      errors++; $display("FAIL acct_pulse: done %0b value %0d required 0 1234", done, value); end
  endtask

  task automatic test_edit;
    int n;
    start_field(2'd2);
    checks++; if (value !== 16'd0 || field_id !== 2'd2) begin
      errors++; $display("FAIL edit_start: value %0d id %0d required 0 2", value, field_id); end
    key("9"); key("8"); key(8'h08);
    checks++; if (digit_count !== 3'd1 || status_code !== 4'd1) begin
      errors++; $display("FAIL edit_bksp: count %0d status %0d required 1 1", digit_count, status_code); end
    key("7"); key(8'h0D);
    wait_done(n);
    checks++; if (done !== 1'b1 || n != 4) begin
      errors++; $display("FAIL edit_latency: done %0b after %0d required 1 after 4", done, n); end
    checks++; if (value !== 16'd97 || digit_count !== 3'd2) begin
      errors++; $display("FAIL edit_result: value %0d count %0d required 97 2", value, digit_count); end
  endtask

  task automatic test_errors;
    int n;
    start_field(2'd1);
    key(8'h08);
    checks++; if (digit_count !== 3'd0) begin
      errors++; $display("FAIL bksp_empty: got %0d required 0", digit_count); end
    key("5"); key("@");
    checks++; if (status_code !== 4'd2 || digit_count !== 3'd1) begin
      errors++; $display("FAIL badchar: status %0d count %0d required 2 1", status_code, digit_count); end
    key("1");
    checks++; if (status_code !== 4'd1) begin
      errors++; $display("FAIL badchar_recover: got %0d required 1", status_code); end
    key(8'h0D);
    checks++; if (status_code !== 4'd4 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL toofew: status %0d busy %0b done %0b required 4 1 0", status_code, busy, done); end
    tick;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL toofew_stay: done %0b busy %0b required 0 1", done, busy); end
    key("2"); key("3"); key("4");
    checks++; if (status_code !== 4'd3 || digit_count !== 3'd4) begin
      errors++; $display("FAIL toomany_first: status %0d count %0d required 3 4", status_code, digit_count); end
    key("6");
    checks++; if (status_code !== 4'd3) begin
      errors++; $display("FAIL toomany: got %0d required 3", status_code); end
    key(8'h0D);
    wait_done(n);
    checks++; if (done !== 1'b1 || value !== 16'd5123 || status_code !== 4'd0 || field_id !== 2'd1) begin
      errors++; $display("FAIL pswd_result: done %0b value %0d status %0d id %0d required 1 5123 0 1", done, value, status_code, field_id); end
  endtask

  task automatic test_currency;
    int n;
    start_field(2'd3);
    key("3"); key(8'h0D);
    checks++; if (status_code !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL cur_range: status %0d busy %0b required 5 1", status_code, busy); end
    key(8'h08); key("2"); key("1");
    checks++; if (status_code !== 4'd3 || digit_count !== 3'd1) begin
      errors++; $display("FAIL cur_limit: status %0d count %0d required 3 1", status_code, digit_count); end
    key(8'h0D);
    wait_done(n);
    checks++; if (done !== 1'b1 || n != 3 || value !== 16'd2) begin
      errors++; $display("FAIL cur_result: done %0b n %0d value %0d required 1 3 2", done, n, value); end
  endtask

  task automatic test_cancel_restart;
    start_field(2'd2);
    key("4"); key(8'h1B);
    checks++; if (done !== 1'b0 || status_code !== 4'd6 || busy !== 1'b0) begin
      errors++; $display("FAIL esc_state: done %0b status %0d busy %0b required 0 6 0", done, status_code, busy); end
    tick;
    checks++; if (done !== 1'b1 || value !== 16'd0 || status_code !== 4'd6) begin
      errors++; $display("FAIL esc_done: done %0b value %0d status %0d required 1 0 6", done, value, status_code); end
    field_sel = 2'd2; start = 1'b1; ascii_code = "7"; ascii_valid = 1'b1;
    tick;
    start = 1'b0; ascii_valid = 1'b0;
    checks++; if (digit_count !== 3'd0 || status_code !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL start_wins: count %0d status %0d busy %0b required 0 1 1", digit_count, status_code, busy); end
    key("5");
    start_field(2'd0);
    checks++; if (digit_count !== 3'd0 || field_id !== 2'd0) begin
      errors++; $display("FAIL restart: count %0d id %0d required 0 0", digit_count, field_id); end
  endtask

  task automatic test_reset_midconvert;
    bit seen;
    seen = 1'b0;
    key("1"); key("2"); key("3"); key("4"); key(8'h0D);
    tick;
    checks++; if (value !== 16'd1) begin
      errors++; $display("FAIL midconv_value: got %0d required 1", value); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, field_id, value, digit_count, status_code} !== 26'd0) begin
      errors++; $display("FAIL async_reset: got %h required 0", {busy, done, field_id, value, digit_count, status_code}); end
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done) seen = 1'b1;
    end
    checks++; if (seen || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_done: done seen %0b busy %0b required 0 0", seen, busy); end
  endtask

  initial begin
    test_reset;
    test_account;
    test_edit;
    test_errors;
    test_currency;
    test_cancel_restart;
    test_reset_midconvert;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
